// File: rtl/bram_capture_ctrl.sv
// Capture controller: fills a BRAM with valid samples, holds them, then drains
// them back out as a stream throttled by the consumer's ready signal.
module bram_capture_ctrl #(
    parameter int NB_ADDR = 15,
    parameter int NB_DATA = 14
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_read_req,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_bram_wdata,
    output logic [NB_ADDR-1:0] o_bram_waddr,
    output logic               o_bram_we,
    output logic [NB_ADDR-1:0] o_bram_raddr,
    output logic               o_bram_re,
    input  logic [NB_DATA-1:0] i_bram_rdata,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic [NB_ADDR:0]   o_count,
    output logic [1:0]         o_state,
    output logic               o_full,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [NB_ADDR:0]   FULL_CNT = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_ADDR:0]   LAST_CNT = FULL_CNT - 1;
    localparam logic [NB_ADDR:0]   ONE_C    = 1;
    localparam logic [NB_ADDR-1:0] ONE_A    = 1;

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   wptr_q, wptr_d;
    logic [NB_ADDR:0]     rptr_q, rptr_d;
    logic [NB_ADDR:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 we_q, we_d;
    logic [NB_ADDR-1:0]   waddr_q, waddr_d;
    logic [NB_DATA-1:0]   wdata_q, wdata_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 rd_issue;

    // Reads are issued combinationally so i_ready gates the same cycle.
    assign rd_issue = (state_q == DRAIN) && i_ready && (rptr_q < count_q);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        full_d  = full_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        valid_d = rd_issue;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FILL;
                    wptr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            FILL: begin
                accept = i_valid && !full_q;
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = i_data;
                    wptr_d  = wptr_q + ONE_A;
                    count_d = count_q + ONE_C;
                    if (count_q == LAST_CNT) full_d = 1'b1;
                end
                // A sample arriving with i_stop is still written before leaving.
                if (i_stop || (accept && count_q == LAST_CNT)) state_d = HOLD;
            end
            HOLD: begin
                if (i_read_req) begin
                    if (count_q != '0) begin
                        state_d = DRAIN;
                        rptr_d  = '0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rd_issue) begin
                    rptr_d = rptr_q + ONE_C;
                    if (rptr_q + ONE_C == count_q) done_d = 1'b1;
                end
                // done_q coincides with the final o_valid; leave right after it.
                if (done_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_bram_we    = we_q;
    assign o_bram_waddr = waddr_q;
    assign o_bram_wdata = wdata_q;
    assign o_bram_re    = rd_issue;
    assign o_bram_raddr = rptr_q[NB_ADDR-1:0];
    assign o_valid      = valid_q;
    assign o_data       = valid_q ? i_bram_rdata : '0;
    assign o_count      = count_q;
    assign o_state      = state_q;
    assign o_full       = full_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl with a behavioural BRAM and a queue-based
// reference of which samples must be stored and streamed back.
module tb_bram_capture_ctrl;
    localparam int NA = 3;
    localparam int ND = 8;

    logic          clock = 1'b0;
    logic          i_reset = 1'b1, i_start = 1'b0, i_stop = 1'b0, i_valid = 1'b0;
    logic          i_read_req = 1'b0, i_ready = 1'b0;
    logic [ND-1:0] i_data = '0;
    logic [ND-1:0] i_bram_rdata = '0;
    logic [ND-1:0] o_bram_wdata, o_data;
    logic [NA-1:0] o_bram_waddr, o_bram_raddr;
    logic          o_bram_we, o_bram_re, o_valid, o_full, o_done;
    logic [NA:0]   o_count;
    logic [1:0]    o_state;

    int checks = 0;
    int failures = 0;

    logic [ND-1:0] mem [0:7];
    logic [NA-1:0] wr_a_q[$];
    logic [ND-1:0] wr_d_q[$];
    logic [NA-1:0] ra_q[$];
    logic [ND-1:0] rd_q[$];

    always #5 clock = ~clock;

    bram_capture_ctrl #(.NB_ADDR(NA), .NB_DATA(ND)) dut (
        .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_data(i_data), .i_valid(i_valid), .i_read_req(i_read_req), .i_ready(i_ready),
        .o_bram_wdata(o_bram_wdata), .o_bram_waddr(o_bram_waddr), .o_bram_we(o_bram_we),
        .o_bram_raddr(o_bram_raddr), .o_bram_re(o_bram_re), .i_bram_rdata(i_bram_rdata),
        .o_data(o_data), .o_valid(o_valid), .o_count(o_count), .o_state(o_state),
        .o_full(o_full), .o_done(o_done)
    );

    // 1-cycle-latency BRAM plus transaction monitors
    always @(posedge clock) begin
        if (o_bram_we) begin
            mem[o_bram_waddr] <= o_bram_wdata;
            wr_a_q.push_back(o_bram_waddr);
            wr_d_q.push_back(o_bram_wdata);
        end
        if (o_bram_re) begin
            i_bram_rdata <= mem[o_bram_raddr];
            ra_q.push_back(o_bram_raddr);
        end
        if (o_valid) rd_q.push_back(o_data);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_samples(input int n, input logic [ND-1:0] base);
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1; i_data = ND'(int'(base) + k); step();
        end
        i_valid = 1'b0; i_stop = 1'b1; step(); i_stop = 1'b0;
    endtask

    task automatic drain_to_idle();
        i_ready = 1'b1; i_read_req = 1'b1; step(); i_read_req = 1'b0;
        for (int c = 0; c < 40 && o_state != 2'd0; c++) step();
        i_ready = 1'b0;
        checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL drain_to_idle_timeout state=%0d exp=0", o_state); end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; step(); step();
        checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if (o_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if ({o_bram_we, o_bram_re, o_valid, o_done, o_full} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {o_bram_we, o_bram_re, o_valid, o_done, o_full}); end
        checks++; if ({o_bram_waddr, o_bram_raddr, o_bram_wdata, o_data} !== '0) begin failures++; $display("FAIL reset_buses got=%h exp=0", {o_bram_waddr, o_bram_raddr, o_bram_wdata, o_data}); end
        i_reset = 1'b0; step();
    endtask

    task automatic test_fill_stop();
        i_start = 1'b1; step(); i_start = 1'b0;
        checks++; if (o_state !== 2'd1 || o_count !== '0) begin failures++; $display("FAIL fill_enter state=%0d count=%0d exp=1/0", o_state, o_count); end
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1; i_data = ND'(8'h11 + k); step();
            checks++;
            if (o_bram_we !== 1'b1 || o_bram_waddr !== NA'(k) || o_bram_wdata !== ND'(8'h11 + k) || o_count !== (NA+1)'(k + 1)) begin
                failures++; $display("FAIL fill_write%0d we=%b addr=%0d data=%h count=%0d exp=1/%0d/%h/%0d", k, o_bram_we, o_bram_waddr, o_bram_wdata, o_count, k, 8'h11 + k, k + 1);
            end
        end
        i_valid = 1'b0; i_stop = 1'b1; step(); i_stop = 1'b0;
        checks++; if (o_state !== 2'd2 || o_count !== 4'd5 || o_bram_we !== 1'b0 || o_full !== 1'b0) begin failures++; $display("FAIL fill_stop state=%0d count=%0d we=%b full=%b exp=2/5/0/0", o_state, o_count, o_bram_we, o_full); end
    endtask

    task automatic test_drain_basic();
        i_ready = 1'b1; i_read_req = 1'b1; step(); i_read_req = 1'b0;
        checks++; if (o_state !== 2'd3) begin failures++; $display("FAIL drain_enter state=%0d exp=3", o_state); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (o_bram_re !== 1'b1 || o_bram_raddr !== NA'(k)) begin failures++; $display("FAIL drain_read%0d re=%b addr=%0d exp=1/%0d", k, o_bram_re, o_bram_raddr, k); end
            step();
            checks++; if (o_valid !== 1'b1 || o_data !== ND'(8'h11 + k) || o_done !== (k == 4)) begin failures++; $display("FAIL drain_data%0d valid=%b data=%h done=%b exp=1/%h/%0d", k, o_valid, o_data, o_done, 8'h11 + k, k == 4); end
        end
        checks++; if (o_bram_re !== 1'b0) begin failures++; $display("FAIL drain_extra_read re=%b exp=0", o_bram_re); end
        step(); i_ready = 1'b0;
        checks++; if (o_state !== 2'd0 || o_valid !== 1'b0 || o_done !== 1'b0 || o_count !== 4'd5) begin failures++; $display("FAIL drain_end state=%0d valid=%b done=%b count=%0d exp=0/0/0/5", o_state, o_valid, o_done, o_count); end
    endtask

    task automatic test_ignore();
        i_read_req = 1'b1; step(); i_read_req = 1'b0;
        checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL idle_read_req state=%0d exp=0", o_state); end
        i_start = 1'b1; step(); step(); i_start = 1'b0;
        checks++; if (o_state !== 2'd1 || o_count !== '0) begin failures++; $display("FAIL fill_restart state=%0d count=%0d exp=1/0", o_state, o_count); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        i_start = 1'b1; step(); i_start = 1'b0;
        checks++; if (o_state !== 2'd2) begin failures++; $display("FAIL hold_start state=%0d exp=2", o_state); end
        i_read_req = 1'b1; step(); i_read_req = 1'b0;
        checks++; if (o_state !== 2'd0 || o_done !== 1'b1) begin failures++; $display("FAIL empty_read state=%0d done=%b exp=0/1", o_state, o_done); end
        step();
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL empty_done_pulse done=%b exp=0", o_done); end
    endtask

    task automatic test_full();
        wr_a_q.delete(); wr_d_q.delete();
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1; i_data = ND'(8'h30 + k); step();
        end
        i_valid = 1'b0; step();
        checks++; if (wr_a_q.size() != 8) begin failures++; $display("FAIL full_write_count got=%0d exp=8", wr_a_q.size()); end
        for (int i = 0; i < wr_a_q.size() && i < 8; i++) begin
            checks++; if (wr_a_q[i] !== NA'(i) || wr_d_q[i] !== ND'(8'h30 + i)) begin failures++; $display("FAIL full_write%0d addr=%0d data=%h exp=%0d/%h", i, wr_a_q[i], wr_d_q[i], i, 8'h30 + i); end
        end
        checks++; if (o_full !== 1'b1 || o_state !== 2'd2 || o_count !== 4'd8) begin failures++; $display("FAIL full_status full=%b state=%0d count=%0d exp=1/2/8", o_full, o_state, o_count); end
    endtask

    task automatic test_stop_same_cycle();
        i_start = 1'b1; step(); i_start = 1'b0;
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL start_clears_full full=%b exp=0", o_full); end
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_data = ND'(8'h20 + k); step();
        end
        i_data = 8'hAA; i_stop = 1'b1; step(); i_valid = 1'b0; i_stop = 1'b0;
        checks++; if (o_bram_we !== 1'b1 || o_bram_waddr !== 3'd3 || o_bram_wdata !== 8'hAA || o_count !== 4'd4 || o_state !== 2'd2) begin
            failures++; $display("FAIL stop_with_valid we=%b addr=%0d data=%h count=%0d state=%0d exp=1/3/aa/4/2", o_bram_we, o_bram_waddr, o_bram_wdata, o_count, o_state);
        end
        step();
        checks++; if (o_bram_we !== 1'b0) begin failures++; $display("FAIL hold_we we=%b exp=0", o_bram_we); end
    endtask

    task automatic test_drain_stall();
        bit seen = 1'b0;
        fill_samples(5, 8'h40);
        ra_q.delete(); rd_q.delete();
        i_ready = 1'b0; i_read_req = 1'b1; step(); i_read_req = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            i_ready = (c % 2 == 0); #1;
            checks++; if (o_bram_re === 1'b1 && i_ready !== 1'b1) begin failures++; $display("FAIL stall_read_cycle%0d re=%b ready=%b exp=0", c, o_bram_re, i_ready); end
            step();
            seen = o_done;
        end
        i_ready = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL stall_done_timeout done=0 exp=1"); end
        step();
        checks++; if (ra_q.size() != 5 || rd_q.size() != 5) begin failures++; $display("FAIL stall_counts reads=%0d valids=%0d exp=5/5", ra_q.size(), rd_q.size()); end
        for (int i = 0; i < 5 && i < ra_q.size() && i < rd_q.size(); i++) begin
            checks++; if (ra_q[i] !== NA'(i) || rd_q[i] !== ND'(8'h40 + i)) begin failures++; $display("FAIL stall_item%0d addr=%0d data=%h exp=%0d/%h", i, ra_q[i], rd_q[i], i, 8'h40 + i); end
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_samples(5, 8'h50);
        i_ready = 1'b1; i_read_req = 1'b1; step(); i_read_req = 1'b0;
        step(); step();
        i_reset = 1'b1; step();
        checks++; if (o_state !== 2'd0 || o_count !== '0 || {o_bram_we, o_bram_re, o_valid, o_done, o_full} !== 5'b0) begin
            failures++; $display("FAIL mid_drain_reset state=%0d count=%0d flags=%b exp=0/0/00000", o_state, o_count, {o_bram_we, o_bram_re, o_valid, o_done, o_full});
        end
        checks++; if ({o_bram_waddr, o_bram_raddr, o_bram_wdata, o_data} !== '0) begin failures++; $display("FAIL mid_drain_buses got=%h exp=0", {o_bram_waddr, o_bram_raddr, o_bram_wdata, o_data}); end
        i_reset = 1'b0; step(); i_ready = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_state !== 2'd0) begin failures++; $display("FAIL after_reset valid=%b state=%0d exp=0/0", o_valid, o_state); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [ND-1:0] exp_q[$];
            int  stop_at;
            bit  seen;
            stop_at = $urandom_range(0, 11);
            wr_a_q.delete(); wr_d_q.delete();
            i_start = 1'b1; step(); i_start = 1'b0;
            for (int c = 0; c < 16; c++) begin
                i_valid = $urandom_range(0, 1) == 1;
                i_data  = ND'($urandom);
                i_stop  = (c == stop_at);
                if (i_valid && exp_q.size() < 8) exp_q.push_back(i_data);
                step();
                if (c == stop_at || exp_q.size() == 8) break;
            end
            i_valid = 1'b0; i_stop = 1'b0; step();
            checks++; if (o_state !== 2'd2 || o_count !== (NA+1)'(exp_q.size()) || o_full !== (exp_q.size() == 8)) begin
                failures++; $display("FAIL rand%0d_hold state=%0d count=%0d full=%b exp=2/%0d/%0d", it, o_state, o_count, o_full, exp_q.size(), exp_q.size() == 8);
            end
            checks++; if (wr_a_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_writes got=%0d exp=%0d", it, wr_a_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < wr_a_q.size(); i++) begin
                checks++; if (wr_a_q[i] !== NA'(i) || wr_d_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_write%0d addr=%0d data=%h exp=%0d/%h", it, i, wr_a_q[i], wr_d_q[i], i, exp_q[i]); end
            end
            ra_q.delete(); rd_q.delete();
            i_read_req = 1'b1; step(); i_read_req = 1'b0;
            seen = o_done;
            for (int c = 0; c < 60 && !seen; c++) begin
                i_ready = $urandom_range(0, 1) == 1;
                step();
                seen = o_done;
            end
            i_ready = 1'b0;
            checks++; if (!seen) begin failures++; $display("FAIL rand%0d_done_timeout done=0 exp=1", it); end
            step();
            checks++; if (o_state !== 2'd0 || rd_q.size() != exp_q.size() || ra_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_drain state=%0d valids=%0d reads=%0d exp=0/%0d/%0d", it, o_state, rd_q.size(), ra_q.size(), exp_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rd_q.size() && i < ra_q.size(); i++) begin
                checks++; if (rd_q[i] !== exp_q[i] || ra_q[i] !== NA'(i)) begin failures++; $display("FAIL rand%0d_read%0d addr=%0d data=%h exp=%0d/%h", it, i, ra_q[i], rd_q[i], i, exp_q[i]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_fill_stop();
        test_drain_basic();
        test_ignore();
        test_full();
        drain_to_idle();
        test_stop_same_cycle();
        drain_to_idle();
        test_drain_stall();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
